washer_sense_timer: RTL



---
 rtl/washer_sense_timer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/washer_sense_timer.sv
// Plant-side level sense, wash/spin timers and detergent dispenser that closes
// the loop around the washing-machine controller. Every output is registered.
module washer_sense_timer #(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 5,
  parameter int TIMER_W     = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int DET_TICKS   = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               motor_on,
  input  logic               door_lock,
  input  logic               soap_wash,
  input  logic               spin_req,
  input  logic               done,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] water_level,
  output logic               fault
);

  localparam logic [LEVEL_W-1:0] FULL_LIM  = LEVEL_W'(FULL_LEVEL);
  localparam logic [TIMER_W-1:0] CYCLE_LIM = TIMER_W'(CYCLE_TICKS);
  localparam logic [TIMER_W-1:0] SPIN_LIM  = TIMER_W'(SPIN_TICKS);
  localparam logic [TIMER_W-1:0] DET_LIM   = TIMER_W'(DET_TICKS);

  typedef enum logic [1:0] {IDLE, DISPENSE, ADDED, LOCKED} disp_state_t;

  disp_state_t        state, state_n;
  logic [TIMER_W-1:0] cycle_cnt, cycle_cnt_n;
  logic [TIMER_W-1:0] spin_cnt, spin_cnt_n;
  logic [TIMER_W-1:0] det_cnt, det_cnt_n;
  logic [LEVEL_W-1:0] level_n;
  logic               cycle_to_n, spin_to_n, fault_n;
  logic               motor_prev, spin_prev, soap_prev, door_prev;
  logic               motor_rise, spin_rise, soap_rise, clr;

  function automatic logic [LEVEL_W-1:0] sat_fill(input logic [LEVEL_W-1:0] lvl);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, lvl} + (LEVEL_W+1)'(FILL_RATE);
    return sum[LEVEL_W] ? {LEVEL_W{1'b1}} : sum[LEVEL_W-1:0];
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_drain(input logic [LEVEL_W-1:0] lvl);
    logic [LEVEL_W:0] dif;
    dif = {1'b0, lvl} - (LEVEL_W+1)'(DRAIN_RATE);
    return dif[LEVEL_W] ? '0 : dif[LEVEL_W-1:0];
  endfunction

  // A rising run edge restarts the timer only once the previous period has
  // expired; a rise after a pause resumes the count instead.
  function automatic logic [TIMER_W:0] timer_next(
    input logic               run,
    input logic               rise,
    input logic               clr_all,
    input logic               ena,
    input logic               to,
    input logic [TIMER_W-1:0] cnt,
    input logic [TIMER_W-1:0] lim
  );
    logic [TIMER_W-1:0] c;
    logic               t;
    c = cnt;
    t = to;
    if (clr_all || (rise && to)) begin
      c = '0;
      t = 1'b0;
    end
    if (!clr_all && run && ena && (c != lim)) begin
      c = c + TIMER_W'(1);
      if (c == lim) t = 1'b1;
    end
    return {t, c};
  endfunction

  assign motor_rise = motor_on  & ~motor_prev;
  assign spin_rise  = spin_req  & ~spin_prev;
  assign soap_rise  = soap_wash & ~soap_prev;
  assign clr        = done | (door_prev & ~door_lock);

  always_comb begin
    level_n = water_level;
    if (tick) begin
      if (fill_value_on && !drain_value_on)      level_n = sat_fill(water_level);
      else if (drain_value_on && !fill_value_on) level_n = sat_drain(water_level);
    end
    fault_n = fault | (fill_value_on & drain_value_on) | (motor_on & (water_level < FULL_LIM));
    {cycle_to_n, cycle_cnt_n} = timer_next(motor_on, motor_rise, clr, tick, cycle_timeout,
                                           cycle_cnt, CYCLE_LIM);
    {spin_to_n, spin_cnt_n}   = timer_next(spin_req, spin_rise, clr, tick, spin_timeout,
                                           spin_cnt, SPIN_LIM);
  end

  always_comb begin
    state_n   = state;
    det_cnt_n = det_cnt;
    if (clr) begin
      state_n   = IDLE;
      det_cnt_n = '0;
    end else begin
      case (state)
        IDLE: if (soap_rise && filled) begin
          state_n   = DISPENSE;
          det_cnt_n = '0;
        end
        DISPENSE: if (tick) begin
          det_cnt_n = det_cnt + TIMER_W'(1);
          if (det_cnt_n == DET_LIM) state_n = ADDED;
        end
        ADDED: if (motor_rise) state_n = LOCKED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      det_cnt         <= '0;
      cycle_cnt       <= '0;
      spin_cnt        <= '0;
      motor_prev      <= 1'b0;
      spin_prev       <= 1'b0;
      soap_prev       <= 1'b0;
      door_prev       <= 1'b0;
      water_level     <= '0;
      filled          <= 1'b0;
      drained         <= 1'b1;
      detergent_added <= 1'b0;
      cycle_timeout   <= 1'b0;
      spin_timeout    <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_n;
      det_cnt         <= det_cnt_n;
      cycle_cnt       <= cycle_cnt_n;
      spin_cnt        <= spin_cnt_n;
      motor_prev      <= motor_on;
      spin_prev       <= spin_req;
      soap_prev       <= soap_wash;
      door_prev       <= door_lock;
      water_level     <= level_n;
      filled          <= (level_n >= FULL_LIM);
      drained         <= (level_n == '0);
      detergent_added <= (state_n == ADDED);
      cycle_timeout   <= cycle_to_n;
      spin_timeout    <= spin_to_n;
      fault           <= fault_n;
    end
  end

endmodule
